mem_word_writer: RTL and testbench

Write-side memory controller that takes one 32-bit store request and serializes it onto the 8-bit memory bus as consecutive byte writes, most-significant byte at the lowest address. It matches the byte order of the word-assembling read controller, so a word written here reads back identically. It sits between the CPU memory stage and the byte-wide RAM/IO port.

---
 rtl/mwr_pkg.sv | 23 ++
 rtl/mem_word_writer.sv | 150 +++++++++++++++
 tb/tb_mem_word_writer.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/mwr_pkg.sv
// Shared definitions for the byte-serialising store controller:
// FSM state encoding, store size codes and the final-byte index helper.
package mwr_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  // Index of the last byte sent for a given store size; code 3 is a word.
  function automatic logic [1:0] last_idx(input logic [1:0] size);
    case (size)
      SZ_BYTE: last_idx = 2'd0;
      SZ_HALF: last_idx = 2'd1;
      default: last_idx = 2'd3;
    endcase
  endfunction

endpackage

// File: rtl/mem_word_writer.sv
// mem_word_writer: serialises one 32-bit store onto an 8-bit memory bus,
// most-significant byte at the lowest address, one byte per cycle.
// Optional macro MWR_SIZE_EN adds the size_i port for byte/half/word stores;
// without it every request is a 4-byte word store.
// All outputs are registered: the controller computes the next bus value in
// the same cycle it decides the next state, so byte 0 appears in the cycle
// right after the request is accepted.
module mem_word_writer
  import mwr_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [31:0]       data_i,
`ifdef MWR_SIZE_EN
  input  logic [1:0]        size_i,
`endif
  output logic              ready_o,
  output logic              done_o,
  output logic [ADDR_W-1:0] mem_a_o,
  output logic [7:0]        mem_dout_o,
  output logic              mem_wr_o
);

  state_t            state, nxt_state;
  logic [1:0]        cnt, nxt_cnt;
  logic              nxt_ready, nxt_done, nxt_wr;
  logic [ADDR_W-1:0] nxt_a;
  logic [7:0]        nxt_dout;
  logic              load;

  // Latched request (data path, not reset)
  logic [ADDR_W-1:0] base_q;
  logic [31:0]       data_q;
  logic [1:0]        size_q;
  logic [1:0]        size_in;

  // Byte-mux operands: the incoming request when idle, the latched one when sending
  logic [31:0]       sel_data;
  logic [1:0]        sel_size;
  logic [1:0]        sel_cnt;
  logic [7:0]        sel_byte;

`ifdef MWR_SIZE_EN
  assign size_in = size_i;
`else
  assign size_in = SZ_WORD;
`endif

  // Choose which request and which byte index feed the next bus value
  always_comb begin
    sel_data = data_q;
    sel_size = size_q;
    sel_cnt  = cnt + 2'd1;
    if (state == IDLE) begin
      sel_data = data_i;
      sel_size = size_in;
      sel_cnt  = 2'd0;
    end
  end

  // Byte mux: MSB-first within the stored width
  always_comb begin
    sel_byte = sel_data[7:0];
    case (sel_size)
      SZ_BYTE: sel_byte = sel_data[7:0];
      SZ_HALF: sel_byte = sel_cnt[0] ? sel_data[7:0] : sel_data[15:8];
      default: begin
        case (sel_cnt)
          2'd0:    sel_byte = sel_data[31:24];
          2'd1:    sel_byte = sel_data[23:16];
          2'd2:    sel_byte = sel_data[15:8];
          default: sel_byte = sel_data[7:0];
        endcase
      end
    endcase
  end

  // Next-state and next-output logic; done_o defaults low so it only pulses
  always_comb begin
    nxt_state = state;
    nxt_cnt   = cnt;
    nxt_ready = ready_o;
    nxt_done  = 1'b0;
    nxt_wr    = mem_wr_o;
    nxt_a     = mem_a_o;
    nxt_dout  = mem_dout_o;
    load      = 1'b0;
    case (state)
      IDLE: begin
        if (req_i) begin
          load      = 1'b1;
          nxt_state = SEND;
          nxt_cnt   = 2'd0;
          nxt_ready = 1'b0;
          nxt_wr    = 1'b1;
          nxt_a     = addr_i;
          nxt_dout  = sel_byte;
        end
      end
      SEND: begin
        if (cnt == last_idx(size_q)) begin
          nxt_state = IDLE;
          nxt_ready = 1'b1;
          nxt_done  = 1'b1;
          nxt_wr    = 1'b0;
        end else begin
          nxt_cnt  = sel_cnt;
          nxt_a    = base_q + ADDR_W'(sel_cnt);
          nxt_dout = sel_byte;
        end
      end
      default: nxt_state = IDLE;
    endcase
  end

  // Control and bus registers; reset aborts any transfer in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= 2'd0;
      ready_o    <= 1'b1;
      done_o     <= 1'b0;
      mem_wr_o   <= 1'b0;
      mem_a_o    <= '0;
      mem_dout_o <= 8'd0;
    end else begin
      state      <= nxt_state;
      cnt        <= nxt_cnt;
      ready_o    <= nxt_ready;
      done_o     <= nxt_done;
      mem_wr_o   <= nxt_wr;
      mem_a_o    <= nxt_a;
      mem_dout_o <= nxt_dout;
    end
  end

  // Capture the request when it is accepted
  always_ff @(posedge clk) begin
    if (load) begin
      base_q <= addr_i;
      data_q <= data_i;
      size_q <= size_in;
    end
  end

endmodule

// File: tb/tb_mem_word_writer.sv
// Directed self-checking bench for mem_word_writer.
// Inputs change and outputs are sampled 1 ns after each rising edge.
module tb_mem_word_writer;
  import mwr_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_i;
  logic [31:0] addr_i;
  logic [31:0] data_i;
  logic [1:0]  size_i;
  logic        ready_o;
  logic        done_o;
  logic [31:0] mem_a_o;
  logic [7:0]  mem_dout_o;
  logic        mem_wr_o;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_word_writer #(.ADDR_W(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_i      (req_i),
    .addr_i     (addr_i),
    .data_i     (data_i),
`ifdef MWR_SIZE_EN
    .size_i     (size_i),
`endif
    .ready_o    (ready_o),
    .done_o     (done_o),
    .mem_a_o    (mem_a_o),
    .mem_dout_o (mem_dout_o),
    .mem_wr_o   (mem_wr_o)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, " wr"},    32'(mem_wr_o), 32'd0);
    chk({tag, " ready"}, 32'(ready_o),  32'd1);
    chk({tag, " done"},  32'(done_o),   32'd0);
  endtask

  // Issue a store in the current cycle and check every bus byte and done.
  // exp holds the expected bytes MSB-first in its top n bytes.
  // With hold=1 a second, different request is kept asserted during SEND.
  task automatic store(input string tag, input logic [31:0] addr, input logic [31:0] data,
                       input logic [1:0] sz, input int n, input logic [31:0] exp, input bit hold);
    logic [31:0] e;
    e      = exp;
    req_i  = 1'b1;
    addr_i = addr;
    data_i = data;
    size_i = sz;
    tick();
    if (hold) begin
      addr_i = 32'h0000_0300;
      data_i = 32'h5A5A_5A5A;
    end else begin
      req_i = 1'b0;
    end
    for (int k = 0; k < n; k++) begin
      chk($sformatf("%s b%0d wr", tag, k),    32'(mem_wr_o),   32'd1);
      chk($sformatf("%s b%0d addr", tag, k),  mem_a_o,         addr + 32'(k));
      chk($sformatf("%s b%0d data", tag, k),  32'(mem_dout_o), 32'(e[31:24]));
      chk($sformatf("%s b%0d ready", tag, k), 32'(ready_o),    32'd0);
      chk($sformatf("%s b%0d done", tag, k),  32'(done_o),     32'd0);
      e = e << 8;
      if (k == n - 1) req_i = 1'b0;
      tick();
    end
    chk({tag, " done"},  32'(done_o),   32'd1);
    chk({tag, " ready"}, 32'(ready_o),  32'd1);
    chk({tag, " wr"},    32'(mem_wr_o), 32'd0);
  endtask

  initial begin
    rst    = 1'b1;
    req_i  = 1'b0;
    addr_i = '0;
    data_i = '0;
    size_i = SZ_WORD;
    tick();
    tick();
    chk_idle("reset");
    chk("reset addr", mem_a_o, 32'd0);
    chk("reset dout", 32'(mem_dout_o), 32'd0);
    rst = 1'b0;
    tick();
    chk_idle("post-reset");

    // Word store, then a back-to-back word issued in the done cycle with a
    // competing request held high throughout its transfer
    store("w1", 32'h0000_0100, 32'hDEAD_BEEF, SZ_WORD, 4, 32'hDEAD_BEEF, 1'b0);
    store("w2", 32'h0000_0200, 32'h0102_0304, SZ_WORD, 4, 32'h0102_0304, 1'b1);
    tick();
    chk_idle("after w2");
    chk("after w2 addr held", mem_a_o, 32'h0000_0203);
    chk("after w2 dout held", 32'(mem_dout_o), 32'h04);

    // Address wrap across 2^32
    store("wrap", 32'hFFFF_FFFE, 32'h1122_3344, SZ_WORD, 4, 32'h1122_3344, 1'b0);
    tick();
    chk_idle("after wrap");

    // Reset during byte 1 aborts the transfer
    req_i  = 1'b1;
    addr_i = 32'h0000_0400;
    data_i = 32'hCAFE_F00D;
    size_i = SZ_WORD;
    tick();
    req_i = 1'b0;
    chk("abort b0 data", 32'(mem_dout_o), 32'hCA);
    tick();
    chk("abort b1 addr", mem_a_o, 32'h0000_0401);
    chk("abort b1 data", 32'(mem_dout_o), 32'hFE);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_idle("abort next");
    chk("abort addr", mem_a_o, 32'd0);
    tick();
    chk_idle("abort +2");
    tick();
    chk_idle("abort +3");
    store("w3", 32'h0000_0500, 32'h5566_7788, SZ_WORD, 4, 32'h5566_7788, 1'b0);
    tick();
    chk_idle("after w3");

`ifdef MWR_SIZE_EN
    store("half", 32'h0000_0010, 32'hAABB_CCDD, SZ_HALF, 2, 32'hCCDD_0000, 1'b0);
    tick();
    chk_idle("after half");
    store("byte", 32'h0000_0020, 32'hAABB_CCDD, SZ_BYTE, 1, 32'hDD00_0000, 1'b0);
    tick();
    chk_idle("after byte");
    store("sz3", 32'h0000_0030, 32'hAABB_CCDD, 2'd3, 4, 32'hAABB_CCDD, 1'b0);
    tick();
    chk_idle("after sz3");
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
